fifo_wr_arbiter: RTL and testbench
==================================

FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 SHALL have parameter N, default 4, number of write requesters.
REQ-002 SHALL have parameter B, default 8, data word width in bits.
REQ-003 SHALL have parameter W, default 4, FIFO address bits (depth 2**W).
REQ-004 SHALL have parameter MAX_BURST, default 4, maximum writes per grant, range 1..15.
REQ-005 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-006 SHALL have port reset_n  input  1  reset, asynchronous and active-low.
REQ-007 SHALL have port req  input  N  per-requester write request; bit i belongs to requester i.
REQ-008 SHALL have port req_data  input  N*B  packed write data; requester i occupies bits [i*B+B-1 : i*B].
REQ-009 SHALL have port gnt  output  N  one-hot-or-zero grant; a beat transfers when req[i] and gnt[i] are both high in the same cycle.
REQ-010 SHALL have port fifo_full  input  1  FIFO full flag.
REQ-011 SHALL have port fifo_empty  input  1  FIFO empty flag.
REQ-012 SHALL have port fifo_rd  input  1  consumer read strobe to the FIFO, monitored only.
REQ-013 SHALL have port fifo_wr  output  1  FIFO write strobe.
REQ-014 SHALL have port fifo_w_data  output  B  FIFO write data.
REQ-015 SHALL have port level  output  W+1  tracked FIFO occupancy, 0..2**W.
REQ-016 SHALL have port busy  output  1  high while the FSM is in GRANT.

Function
REQ-017 SHALL implement a 2-state FSM, IDLE and GRANT, with registered owner index, beat counter and last-served pointer.
REQ-018 In IDLE with req nonzero, SHALL latch as owner the first set req bit searching upward from (last+1) mod N, wrapping, and move to GRANT next cycle.
REQ-019 In IDLE, gnt SHALL be 0 and fifo_wr SHALL be 0.
REQ-020 In GRANT, gnt[owner] SHALL equal ~fifo_full and all other gnt bits SHALL be 0.
REQ-021 fifo_wr SHALL equal req[owner] & gnt[owner], combinationally in the same cycle; fifo_wr SHALL never be high while fifo_full is high.
REQ-022 fifo_w_data SHALL be the owner's req_data slice whenever in GRANT, and 0 in IDLE.
REQ-023 Each transfer SHALL increment the beat counter; GRANT SHALL exit to IDLE after the transfer that makes beats equal MAX_BURST, or in any cycle where req[owner] is low.
REQ-024 While fifo_full is high in GRANT with req[owner] high, the FSM SHALL hold GRANT with owner and beats unchanged (stall; no timeout).
REQ-025 On GRANT exit, last SHALL be loaded with owner; IDLE always lasts at least one cycle between grants.
REQ-026 Latency: req rising in IDLE in cycle t SHALL yield gnt and the first fifo_wr in cycle t+1 if fifo_full is low.
REQ-027 level SHALL update each cycle by +1 on fifo_wr and -1 on (fifo_rd & ~fifo_empty); simultaneous push and pop SHALL leave level unchanged.
REQ-028 level SHALL saturate at 0 and 2**W and never wrap.
REQ-029 Deassertion of req[owner] mid-burst SHALL end the grant without a transfer in that cycle.

Reset
REQ-030 While reset_n is low, SHALL force state IDLE, owner 0, beats 0, last N-1 (so requester 0 wins first), and level 0.
REQ-031 During reset, outputs SHALL be gnt 0, fifo_wr 0, fifo_w_data 0, busy 0, level 0.
REQ-032 Reset asserted mid-burst SHALL abort the burst immediately, with no fifo_wr in the reset cycle.

Structure
REQ-033 A shared package fifo_arb_pkg SHALL hold the IDLE/GRANT state encoding and the default N, B, W and MAX_BURST constants.
REQ-034 Round-robin selection SHALL be a combinational sub-module fifo_rr_pick with inputs req[N] and last, and outputs valid and idx.

Verification
REQ-035 Scenario: after reset, req=4'b1111 held with FIFO never full -> owners 0,1,2,3,0; each grants 4 writes, with one IDLE cycle between grants.
REQ-036 Scenario: req=4'b0100 for 2 cycles then low -> exactly 2 writes of requester 2's data, and busy drops the cycle after req falls.
REQ-037 Scenario: requester 1 bursting and fifo_full raised for 3 cycles after beat 2 -> gnt=0 and fifo_wr=0 for 3 cycles, then beats 3 and 4 complete.
REQ-038 Scenario: 16 writes with no reads -> level=16 and fifo_full; a further req produces no write; then fifo_rd with a concurrent write -> level stays 16.
REQ-039 Scenario: reset_n pulsed low during beat 2 of requester 3 -> gnt, fifo_wr and level are 0 immediately; next req=4'b1000 is granted to requester 3 one cycle after it is sampled in IDLE.
REQ-040 Scenario: fifo_rd high with fifo_empty high and level=0 -> level stays 0.

Source files
------------

// File: rtl/fifo_arb_pkg.sv
// Shared definitions for the FIFO write arbiter: FSM state encoding and
// default sizing constants.
package fifo_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    localparam int DEF_N         = 4;
    localparam int DEF_B         = 8;
    localparam int DEF_W         = 4;
    localparam int DEF_MAX_BURST = 4;

endpackage

// File: rtl/fifo_rr_pick.sv
// Combinational round-robin picker: first set request bit searching upward
// from (last+1) mod N, wrapping around.
module fifo_rr_pick #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last,
    output logic          valid,
    output logic [IW-1:0] idx
);

    // Scan from the farthest offset down so the nearest requester wins.
    always_comb begin
        valid = 1'b0;
        idx   = '0;
        for (int k = N; k >= 1; k--) begin
            if (req[(int'(last) + k) % N]) begin
                valid = 1'b1;
                idx   = IW'((int'(last) + k) % N);
            end else begin
                valid = valid;
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter granting N requesters bursts of writes into one FIFO,
// with stall on full and a saturating occupancy tracker.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int N         = DEF_N,
    parameter int B         = DEF_B,
    parameter int W         = DEF_W,
    parameter int MAX_BURST = DEF_MAX_BURST
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic [N-1:0]   req,
    input  logic [N*B-1:0] req_data,
    output logic [N-1:0]   gnt,
    input  logic           fifo_full,
    input  logic           fifo_empty,
    input  logic           fifo_rd,
    output logic           fifo_wr,
    output logic [B-1:0]   fifo_w_data,
    output logic [W:0]     level,
    output logic           busy
);

    localparam int         IW    = (N > 1) ? $clog2(N) : 1;
    localparam logic [3:0] MB    = 4'(MAX_BURST);
    localparam logic [W:0] DEPTH = {1'b1, {W{1'b0}}};

    arb_state_t    state_r, state_n;
    logic [IW-1:0] owner_r, owner_n;
    logic [IW-1:0] last_r, last_n;
    logic [3:0]    beats_r, beats_n;
    logic [3:0]    beats_inc_s;
    logic [W:0]    level_r;
    logic          pick_valid_s;
    logic [IW-1:0] pick_idx_s;
    logic [N-1:0]  gnt_s;
    logic          wr_s;
    logic [B-1:0]  data_s;
    logic          push_s, pop_s;

    fifo_rr_pick #(.N(N), .IW(IW)) u_pick (
        .req   (req),
        .last  (last_r),
        .valid (pick_valid_s),
        .idx   (pick_idx_s)
    );

    assign beats_inc_s = beats_r + 4'd1;

    // Next-state and grant/write decode.
    always_comb begin
        state_n = state_r;
        owner_n = owner_r;
        beats_n = beats_r;
        last_n  = last_r;
        gnt_s   = '0;
        wr_s    = 1'b0;
        data_s  = '0;
        case (state_r)
            IDLE: begin
                if (pick_valid_s) begin
                    state_n = GRANT;
                    owner_n = pick_idx_s;
                    beats_n = 4'd0;
                end else begin
                    state_n = IDLE;
                end
            end
            GRANT: begin
                gnt_s[owner_r] = ~fifo_full;
                wr_s           = req[owner_r] & ~fifo_full;
                data_s         = req_data[int'(owner_r)*B +: B];
                if (!req[owner_r]) begin
                    state_n = IDLE;
                    last_n  = owner_r;
                end else if (wr_s) begin
                    beats_n = beats_inc_s;
                    if (beats_inc_s == MB) begin
                        state_n = IDLE;
                        last_n  = owner_r;
                    end else begin
                        state_n = GRANT;
                    end
                end else begin
                    // Full stall: hold owner and beat count.
                    state_n = GRANT;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // FSM, owner, beat counter and last-served registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= IDLE;
            owner_r <= '0;
            beats_r <= 4'd0;
            last_r  <= IW'(N - 1);
        end else begin
            state_r <= state_n;
            owner_r <= owner_n;
            beats_r <= beats_n;
            last_r  <= last_n;
        end
    end

    assign push_s = wr_s;
    assign pop_s  = fifo_rd & ~fifo_empty;

    // Saturating occupancy tracker.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            level_r <= '0;
        end else if (push_s && !pop_s && level_r != DEPTH) begin
            level_r <= level_r + 1'b1;
        end else if (pop_s && !push_s && level_r != '0) begin
            level_r <= level_r - 1'b1;
        end else begin
            level_r <= level_r;
        end
    end

    assign gnt         = gnt_s;
    assign fifo_wr     = wr_s;
    assign fifo_w_data = data_s;
    assign level       = level_r;
    assign busy        = (state_r == GRANT);

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: a per-cycle vector table plus
// hand-written sequences for burst truncation, full stall and mid-burst reset.
module tb_fifo_wr_arbiter;

    logic        clk;
    logic        reset_n;
    logic [3:0]  req;
    logic [31:0] req_data;
    logic [3:0]  gnt;
    logic        fifo_full, fifo_empty, fifo_rd;
    logic        fifo_wr;
    logic [7:0]  fifo_w_data;
    logic [4:0]  level;
    logic        busy;

    int n_cmp = 0;
    int n_mis = 0;

    typedef struct {
        logic [3:0] req;
        logic       full;
        logic       empty;
        logic       rd;
        logic [3:0] e_gnt;
        logic       e_wr;
        logic [7:0] e_data;
        logic       e_busy;
        logic [4:0] e_lvl;
    } vec_t;

    vec_t tbl[$];

    fifo_wr_arbiter dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .req         (req),
        .req_data    (req_data),
        .gnt         (gnt),
        .fifo_full   (fifo_full),
        .fifo_empty  (fifo_empty),
        .fifo_rd     (fifo_rd),
        .fifo_wr     (fifo_wr),
        .fifo_w_data (fifo_w_data),
        .level       (level),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_all(input string tag, input logic [3:0] g, input logic w,
                             input logic [7:0] d, input logic b, input logic [4:0] l);
        check({tag, ".gnt"},   32'(gnt),         32'(g));
        check({tag, ".wr"},    32'(fifo_wr),     32'(w));
        check({tag, ".data"},  32'(fifo_w_data), 32'(d));
        check({tag, ".busy"},  32'(busy),        32'(b));
        check({tag, ".level"}, 32'(level),       32'(l));
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n    = 1'b0;
        req        = 4'h0;
        fifo_full  = 1'b0;
        fifo_empty = 1'b1;
        fifo_rd    = 1'b0;
        repeat (2) @(negedge clk);
        check_all("reset", 4'h0, 1'b0, 8'h00, 1'b0, 5'd0);
        reset_n = 1'b1;
    endtask

    // Advance to just after the next rising edge so new inputs can be driven.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int wr_cnt;
        reset_n    = 1'b0;
        req        = 4'h0;
        req_data   = 32'hA3A2A1A0;
        fifo_full  = 1'b0;
        fifo_empty = 1'b1;
        fifo_rd    = 1'b0;

        // req, full, empty, rd | gnt, wr, data, busy, level
        tbl.push_back('{4'hF, 1'b0, 1'b1, 1'b0, 4'h0, 1'b0, 8'h00, 1'b0, 5'd0});
        tbl.push_back('{4'hF, 1'b0, 1'b1, 1'b0, 4'h1, 1'b1, 8'hA0, 1'b1, 5'd0});
        tbl.push_back('{4'hF, 1'b0, 1'b1, 1'b0, 4'h1, 1'b1, 8'hA0, 1'b1, 5'd1});
        tbl.push_back('{4'hF, 1'b0, 1'b1, 1'b0, 4'h1, 1'b1, 8'hA0, 1'b1, 5'd2});
        tbl.push_back('{4'hF, 1'b0, 1'b1, 1'b0, 4'h1, 1'b1, 8'hA0, 1'b1, 5'd3});
        tbl.push_back('{4'hF, 1'b0, 1'b1, 1'b0, 4'h0, 1'b0, 8'h00, 1'b0, 5'd4});
        tbl.push_back('{4'hF, 1'b0, 1'b1, 1'b0, 4'h2, 1'b1, 8'hA1, 1'b1, 5'd4});
        tbl.push_back('{4'hF, 1'b0, 1'b1, 1'b0, 4'h2, 1'b1, 8'hA1, 1'b1, 5'd5});
        tbl.push_back('{4'hF, 1'b0, 1'b1, 1'b0, 4'h2, 1'b1, 8'hA1, 1'b1, 5'd6});
        tbl.push_back('{4'hF, 1'b0, 1'b1, 1'b0, 4'h2, 1'b1, 8'hA1, 1'b1, 5'd7});
        tbl.push_back('{4'hF, 1'b0, 1'b1, 1'b0, 4'h0, 1'b0, 8'h00, 1'b0, 5'd8});
        tbl.push_back('{4'hF, 1'b0, 1'b1, 1'b0, 4'h4, 1'b1, 8'hA2, 1'b1, 5'd8});
        tbl.push_back('{4'hF, 1'b0, 1'b0, 1'b1, 4'h4, 1'b1, 8'hA2, 1'b1, 5'd9});
        tbl.push_back('{4'hF, 1'b0, 1'b1, 1'b0, 4'h4, 1'b1, 8'hA2, 1'b1, 5'd9});
        tbl.push_back('{4'hF, 1'b0, 1'b1, 1'b0, 4'h4, 1'b1, 8'hA2, 1'b1, 5'd10});
        tbl.push_back('{4'hF, 1'b0, 1'b1, 1'b0, 4'h0, 1'b0, 8'h00, 1'b0, 5'd11});
        tbl.push_back('{4'hF, 1'b0, 1'b1, 1'b0, 4'h8, 1'b1, 8'hA3, 1'b1, 5'd11});
        tbl.push_back('{4'hF, 1'b0, 1'b1, 1'b0, 4'h8, 1'b1, 8'hA3, 1'b1, 5'd12});
        tbl.push_back('{4'hF, 1'b0, 1'b1, 1'b0, 4'h8, 1'b1, 8'hA3, 1'b1, 5'd13});
        tbl.push_back('{4'hF, 1'b0, 1'b1, 1'b0, 4'h8, 1'b1, 8'hA3, 1'b1, 5'd14});
        tbl.push_back('{4'hF, 1'b0, 1'b1, 1'b0, 4'h0, 1'b0, 8'h00, 1'b0, 5'd15});
        tbl.push_back('{4'hF, 1'b0, 1'b1, 1'b0, 4'h1, 1'b1, 8'hA0, 1'b1, 5'd15});
        tbl.push_back('{4'h0, 1'b0, 1'b1, 1'b0, 4'h1, 1'b0, 8'hA0, 1'b1, 5'd16});
        tbl.push_back('{4'hF, 1'b1, 1'b1, 1'b0, 4'h0, 1'b0, 8'h00, 1'b0, 5'd16});
        tbl.push_back('{4'hF, 1'b1, 1'b1, 1'b0, 4'h0, 1'b0, 8'hA1, 1'b1, 5'd16});
        tbl.push_back('{4'hF, 1'b0, 1'b0, 1'b1, 4'h2, 1'b1, 8'hA1, 1'b1, 5'd16});
        tbl.push_back('{4'hF, 1'b0, 1'b1, 1'b0, 4'h2, 1'b1, 8'hA1, 1'b1, 5'd16});
        tbl.push_back('{4'h0, 1'b0, 1'b1, 1'b0, 4'h2, 1'b0, 8'hA1, 1'b1, 5'd16});
        tbl.push_back('{4'h0, 1'b0, 1'b1, 1'b0, 4'h0, 1'b0, 8'h00, 1'b0, 5'd16});

        do_reset();
        foreach (tbl[i]) begin
            next_cycle();
            req        = tbl[i].req;
            fifo_full  = tbl[i].full;
            fifo_empty = tbl[i].empty;
            fifo_rd    = tbl[i].rd;
            @(negedge clk);
            check_all($sformatf("vec%0d", i), tbl[i].e_gnt, tbl[i].e_wr,
                      tbl[i].e_data, tbl[i].e_busy, tbl[i].e_lvl);
        end

        // Empty FIFO: read strobe must not underflow the level.
        do_reset();
        next_cycle();
        fifo_rd = 1'b1;
        fifo_empty = 1'b1;
        repeat (2) begin
            next_cycle();
            @(negedge clk);
            check("empty_rd.level", 32'(level), 32'd0);
        end
        fifo_rd = 1'b0;

        // Requester 2 truncates its burst after two beats.
        do_reset();
        wr_cnt = 0;
        next_cycle();
        req = 4'b0100;
        @(negedge clk);
        check("trunc.idle_gnt", 32'(gnt), 32'h0);
        for (int c = 0; c < 2; c++) begin
            next_cycle();
            @(negedge clk);
            check("trunc.gnt", 32'(gnt), 32'h4);
            check("trunc.data", 32'(fifo_w_data), 32'hA2);
            if (fifo_wr) wr_cnt++;
        end
        next_cycle();
        req = 4'b0000;
        @(negedge clk);
        if (fifo_wr) wr_cnt++;
        check("trunc.busy_fall_cycle", 32'(busy), 32'd1);
        next_cycle();
        @(negedge clk);
        if (fifo_wr) wr_cnt++;
        check("trunc.busy_after", 32'(busy), 32'd0);
        check("trunc.writes", 32'(wr_cnt), 32'd2);
        check("trunc.level", 32'(level), 32'd2);

        // Requester 1 stalled by full for three cycles after beat 2.
        do_reset();
        wr_cnt = 0;
        next_cycle();
        req = 4'b0010;
        for (int c = 0; c < 2; c++) begin
            next_cycle();
            @(negedge clk);
            check("stall.pre_wr", 32'(fifo_wr), 32'd1);
        end
        for (int c = 0; c < 3; c++) begin
            next_cycle();
            fifo_full = 1'b1;
            @(negedge clk);
            check("stall.gnt", 32'(gnt), 32'h0);
            check("stall.wr", 32'(fifo_wr), 32'd0);
            check("stall.busy", 32'(busy), 32'd1);
        end
        for (int c = 0; c < 2; c++) begin
            next_cycle();
            fifo_full = 1'b0;
            @(negedge clk);
            check("stall.post_gnt", 32'(gnt), 32'h2);
            check("stall.post_wr", 32'(fifo_wr), 32'd1);
        end
        next_cycle();
        @(negedge clk);
        check("stall.end_busy", 32'(busy), 32'd0);
        check("stall.level", 32'(level), 32'd4);

        // Reset pulsed during beat 2 of requester 3.
        do_reset();
        next_cycle();
        req = 4'b1000;
        next_cycle();
        next_cycle();
        @(negedge clk);
        check("rst.beat2_wr", 32'(fifo_wr), 32'd1);
        check("rst.beat2_level", 32'(level), 32'd1);
        reset_n = 1'b0;
        #1;
        check_all("rst.mid", 4'h0, 1'b0, 8'h00, 1'b0, 5'd0);
        @(negedge clk);
        reset_n = 1'b1;
        next_cycle();
        @(negedge clk);
        check("rst.regrant_gnt", 32'(gnt), 32'h8);
        check("rst.regrant_data", 32'(fifo_w_data), 32'hA3);
        check("rst.regrant_wr", 32'(fifo_wr), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
